up_counter_mod: RTL and testbench

- Parameterised modulo up-counter with synchronous load, clear and count-enable.
- Provides a terminal-count flag, a registered wrap pulse, an optional one-shot mode and a sticky load-overflow flag.
- Serves as the count-up timebase/sequencer element alongside the team's down-counting blocks.
- Drives tick generators and pattern sequencers.

---
 rtl/up_counter_mod_pkg.sv | 20 ++
 rtl/up_counter_mod_if.sv | 47 ++++
 rtl/up_counter_mod.sv | 93 +++++++++
 tb/tb_up_counter_mod.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/up_counter_mod_pkg.sv
`default_nettype none
// ============================================================================
// Module   : up_counter_pkg
// Purpose  : Shared FSM state encoding and default-terminal helper for the
//            modulo up-counter.
// Revision : 1.0  initial release
// ============================================================================
package up_counter_pkg;

    // One bit is enough: the counter is either counting or parked at MAX.
    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_DONE = 1'b1;

    // Default terminal value for an n-bit counter: the full binary range.
    function automatic int default_max(input int n);
        return (1 << n) - 1;
    endfunction

endpackage : up_counter_pkg
`default_nettype wire

// File: rtl/up_counter_mod_if.sv
`default_nettype none
// ============================================================================
// Module   : up_counter_mod_if
// Purpose  : Control/status bundle between a counter user (master) and the
//            modulo up-counter (slave). Clock and reset travel separately.
// Revision : 1.0  initial release
// ============================================================================
interface up_counter_mod_if #(
    parameter int N = 3
);

    logic         enable;
    logic         load;
    logic [N-1:0] load_value;
    logic         clear;
    logic [N-1:0] count;
    logic         terminal;
    logic         wrap_pulse;
    logic         done;
    logic         overflow;

    modport master (
        output enable,
        output load,
        output load_value,
        output clear,
        input  count,
        input  terminal,
        input  wrap_pulse,
        input  done,
        input  overflow
    );

    modport slave (
        input  enable,
        input  load,
        input  load_value,
        input  clear,
        output count,
        output terminal,
        output wrap_pulse,
        output done,
        output overflow
    );

endinterface : up_counter_mod_if
`default_nettype wire

// File: rtl/up_counter_mod.sv
`default_nettype none
// ============================================================================
// Module   : up_counter_mod
// Purpose  : Modulo up-counter (0..MAX) with synchronous clear/load/enable,
//            terminal decode, registered wrap pulse, optional one-shot stop
//            and sticky load-overflow flag.
// Revision : 1.0  initial release
// ============================================================================
module up_counter_mod
    import up_counter_pkg::*;
#(
    parameter int N        = 3,
    parameter int MAX      = default_max(N),
    parameter int ONE_SHOT = 0
) (
    input  wire logic        clock,
    input  wire logic        reset,
    up_counter_mod_if.slave  bus
);

    // Terminal value held at the counter's own width so every compare stays N bits.
    localparam logic [N-1:0] MAX_VAL = N'(MAX);

    logic [0:0]   r_state;
    logic [N-1:0] r_count;
    logic         r_wrap;
    logic         r_ovf;

    logic [0:0]   w_state_next;
    logic [N-1:0] w_count_next;
    logic         w_wrap_next;
    logic         w_ovf_next;

    // State register: reset dominates everything and acts without a clock edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_RUN;
            r_count <= '0;
            r_wrap  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
            r_wrap  <= w_wrap_next;
            r_ovf   <= w_ovf_next;
        end
    end

    // Next-state logic: clear beats load beats enable; otherwise hold.
    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count;
        w_wrap_next  = 1'b0;
        w_ovf_next   = r_ovf;
        if (bus.clear) begin
            w_state_next = ST_RUN;
            w_count_next = '0;
            w_ovf_next   = 1'b0;
        end else if (bus.load) begin
            if (bus.load_value > MAX_VAL) begin
                // Out-of-range loads clamp to MAX; a one-shot is then already finished.
                w_count_next = MAX_VAL;
                w_ovf_next   = 1'b1;
                w_state_next = (ONE_SHOT != 0) ? ST_DONE : ST_RUN;
            end else begin
                w_count_next = bus.load_value;
                w_state_next = ST_RUN;
            end
        end else if (bus.enable && (r_state == ST_RUN)) begin
            if (r_count == MAX_VAL) begin
                if (ONE_SHOT != 0) begin
                    w_state_next = ST_DONE;
                end else begin
                    w_count_next = '0;
                    w_wrap_next  = 1'b1;
                end
            end else begin
                w_count_next = r_count + 1'b1;
            end
        end
    end

    // Outputs: all flags come straight from registers; terminal is a pure decode of count.
    always_comb begin
        bus.count      = r_count;
        bus.terminal   = (r_count == MAX_VAL);
        bus.wrap_pulse = r_wrap;
        bus.done       = (r_state == ST_DONE);
        bus.overflow   = r_ovf;
    end

endmodule : up_counter_mod
`default_nettype wire

// File: tb/tb_up_counter_mod.sv
`default_nettype none
// ============================================================================
// Module   : tb_up_counter_mod
// Purpose  : Self-checking bench for up_counter_mod. Three instances:
//            A (N=3, MAX=5, wrap), B (N=3, MAX=5, one-shot), C (N=4, MAX=9).
// Revision : 1.0  initial release
// ============================================================================
module tb_up_counter_mod;

    typedef struct {
        int count;
        bit wrap;
        bit done;
        bit ovf;
    } model_t;

    logic clock;
    logic reset;

    int checks   = 0;
    int failures = 0;
    int wa = 0;
    int wb = 0;
    int wc = 0;
    int w0;

    model_t ma = '{0, 1'b0, 1'b0, 1'b0};
    model_t mb = '{0, 1'b0, 1'b0, 1'b0};
    model_t mc = '{0, 1'b0, 1'b0, 1'b0};

    up_counter_mod_if #(.N(3)) ifa ();
    up_counter_mod_if #(.N(3)) ifb ();
    up_counter_mod_if #(.N(4)) ifc ();

    up_counter_mod #(.N(3), .MAX(5), .ONE_SHOT(0)) dut_a (.clock(clock), .reset(reset), .bus(ifa.slave));
    up_counter_mod #(.N(3), .MAX(5), .ONE_SHOT(1)) dut_b (.clock(clock), .reset(reset), .bus(ifb.slave));
    up_counter_mod #(.N(4), .MAX(9), .ONE_SHOT(0)) dut_c (.clock(clock), .reset(reset), .bus(ifc.slave));

    // 10-unit clock period
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural rule set: what one clock edge does to the visible state.
    function automatic model_t mstep(model_t m, int max, bit os,
                                     bit clr, bit ld, int lv, bit en);
        model_t r;
        r = m;
        r.wrap = 1'b0;
        if (clr) begin
            r.count = 0; r.done = 1'b0; r.ovf = 1'b0;
        end else if (ld) begin
            if (lv > max) begin
                r.count = max; r.ovf = 1'b1; r.done = os;
            end else begin
                r.count = lv; r.done = 1'b0;
            end
        end else if (en && !m.done) begin
            if (m.count == max) begin
                if (os) r.done = 1'b1;
                else begin r.count = 0; r.wrap = 1'b1; end
            end else begin
                r.count = m.count + 1;
            end
        end
        return r;
    endfunction

    // Reference model advances on the same edges as the DUTs
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            ma <= '{0, 1'b0, 1'b0, 1'b0};
            mb <= '{0, 1'b0, 1'b0, 1'b0};
            mc <= '{0, 1'b0, 1'b0, 1'b0};
        end else begin
            ma <= mstep(ma, 5, 1'b0, ifa.clear, ifa.load, int'(ifa.load_value), ifa.enable);
            mb <= mstep(mb, 5, 1'b1, ifb.clear, ifb.load, int'(ifb.load_value), ifb.enable);
            mc <= mstep(mc, 9, 1'b0, ifc.clear, ifc.load, int'(ifc.load_value), ifc.enable);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cmp(input string tag, input model_t m, input int max,
                       input logic [31:0] cnt, input logic term, input logic wr,
                       input logic dn, input logic ov);
        chk({tag, ".count"},      cnt,          32'(m.count));
        chk({tag, ".terminal"},   32'(term),    32'(m.count == max));
        chk({tag, ".wrap_pulse"}, 32'(wr),      32'(m.wrap));
        chk({tag, ".done"},       32'(dn),      32'(m.done));
        chk({tag, ".overflow"},   32'(ov),      32'(m.ovf));
    endtask

    // Advance one clock and compare every instance against the model at the falling edge
    task automatic tick();
        @(negedge clock);
        cmp("a", ma, 5, 32'(ifa.count), ifa.terminal, ifa.wrap_pulse, ifa.done, ifa.overflow);
        cmp("b", mb, 5, 32'(ifb.count), ifb.terminal, ifb.wrap_pulse, ifb.done, ifb.overflow);
        cmp("c", mc, 9, 32'(ifc.count), ifc.terminal, ifc.wrap_pulse, ifc.done, ifc.overflow);
        if (ifa.wrap_pulse) wa++;
        if (ifb.wrap_pulse) wb++;
        if (ifc.wrap_pulse) wc++;
    endtask

    // Watchdog: the run must never hang
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        ifa.enable = 0; ifa.load = 0; ifa.load_value = '0; ifa.clear = 0;
        ifb.enable = 0; ifb.load = 0; ifb.load_value = '0; ifb.clear = 0;
        ifc.enable = 0; ifc.load = 0; ifc.load_value = '0; ifc.clear = 0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        tick();
        chk("reset.count", 32'(ifa.count), 0);
        chk("reset.flags", {28'd0, ifa.terminal, ifa.wrap_pulse, ifa.done, ifa.overflow}, 0);

        // Count to 3, then reset between clock edges
        ifa.enable = 1;
        repeat (3) tick();
        chk("pre_reset.count", 32'(ifa.count), 3);
        #2 reset = 1'b1;
        #1;
        chk("async_reset.count", 32'(ifa.count), 0);
        chk("async_reset.flags", {28'd0, ifa.terminal, ifa.wrap_pulse, ifa.done, ifa.overflow}, 0);
        #1 reset = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk("ramp.count", 32'(ifa.count), 32'(i));
            chk("ramp.terminal", 32'(ifa.terminal), (i == 5) ? 1 : 0);
        end

        // Wrap MAX->0 with a single-cycle pulse
        tick();
        chk("wrap.count", 32'(ifa.count), 0);
        chk("wrap.pulse", 32'(ifa.wrap_pulse), 1);
        tick();
        chk("after_wrap.count", 32'(ifa.count), 1);
        chk("after_wrap.pulse", 32'(ifa.wrap_pulse), 0);
        w0 = wa;
        repeat (12) tick();
        chk("wrap12.pulses", 32'(wa - w0), 2);
        chk("wrap12.count", 32'(ifa.count), 1);

        // Load beats enable; out-of-range load clamps and sets sticky overflow
        ifa.enable = 0; ifa.clear = 1;
        tick();
        ifa.clear = 0; ifa.enable = 1;
        repeat (2) tick();
        chk("pre_load.count", 32'(ifa.count), 2);
        ifa.load = 1; ifa.load_value = 3'd4;
        tick();
        chk("load_vs_enable.count", 32'(ifa.count), 4);
        ifa.load_value = 3'd7;
        tick();
        chk("load_clamp.count", 32'(ifa.count), 5);
        chk("load_clamp.overflow", 32'(ifa.overflow), 1);
        ifa.load = 0; ifa.enable = 0;
        tick();
        chk("sticky.overflow", 32'(ifa.overflow), 1);
        ifa.enable = 1;
        tick();
        chk("sticky_wrap.overflow", 32'(ifa.overflow), 1);
        ifa.enable = 0; ifa.clear = 1;
        tick();
        chk("clear.count", 32'(ifa.count), 0);
        chk("clear.overflow", 32'(ifa.overflow), 0);
        ifa.clear = 0;

        // Clear beats load
        ifa.load = 1; ifa.load_value = 3'd2;
        tick();
        chk("load2.count", 32'(ifa.count), 2);
        ifa.clear = 1; ifa.load_value = 3'd3;
        tick();
        chk("clear_vs_load.count", 32'(ifa.count), 0);
        ifa.clear = 0; ifa.load = 0;

        // One-shot: stop at MAX, done follows one cycle later
        ifb.enable = 1;
        repeat (5) tick();
        chk("oneshot.reach.count", 32'(ifb.count), 5);
        chk("oneshot.reach.done", 32'(ifb.done), 0);
        tick();
        chk("oneshot.done", 32'(ifb.done), 1);
        chk("oneshot.hold.count", 32'(ifb.count), 5);
        w0 = wb;
        repeat (10) tick();
        chk("oneshot.frozen.count", 32'(ifb.count), 5);
        chk("oneshot.no_wrap", 32'(wb - w0), 0);
        ifb.load = 1; ifb.load_value = 3'd1;
        tick();
        chk("oneshot.reload.count", 32'(ifb.count), 1);
        chk("oneshot.reload.done", 32'(ifb.done), 0);
        ifb.load = 0;
        tick();
        chk("oneshot.resume.count", 32'(ifb.count), 2);
        ifb.load = 1; ifb.load_value = 3'd6;
        tick();
        chk("oneshot.ovf.count", 32'(ifb.count), 5);
        chk("oneshot.ovf.done", 32'(ifb.done), 1);
        ifb.load = 0;
        tick();
        chk("oneshot.ovf.stays", 32'(ifb.count), 5);
        ifb.enable = 0; ifb.clear = 1;
        tick();
        chk("oneshot.clear.done", 32'(ifb.done), 0);
        ifb.clear = 0;

        // Enable gating on the N=4, MAX=9 instance
        w0 = wc;
        for (int i = 0; i < 20; i++) begin
            ifc.enable = (i % 2 == 0);
            tick();
        end
        chk("gate.count", 32'(ifc.count), 0);
        chk("gate.pulses", 32'(wc - w0), 1);
        ifc.enable = 0; ifc.load = 1; ifc.load_value = 4'd12;
        tick();
        chk("c.clamp.count", 32'(ifc.count), 9);
        chk("c.clamp.overflow", 32'(ifc.overflow), 1);
        ifc.load = 0; ifc.clear = 1;
        tick();
        ifc.clear = 0; ifc.load = 1; ifc.load_value = 4'd9;
        tick();
        chk("c.load_max.count", 32'(ifc.count), 9);
        chk("c.load_max.overflow", 32'(ifc.overflow), 0);
        chk("c.load_max.terminal", 32'(ifc.terminal), 1);
        ifc.load = 0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_up_counter_mod
`default_nettype wire
